// File: rtl/wb_stage_v2.sv
// wb_stage_v2: write-back stage of the 5-stage pipeline.
// Registers the MEM-stage result, extracts and extends sub-word load data,
// selects the register-file write data and drives the RF write port.
// Optional retirement counter: define WB_INSTRET_EN to add instret_o.
module wb_stage_v2 #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0]       mem_pc_i,
  input  logic [XLEN-1:0]       mem_imm_i,
  input  logic [XLEN-1:0]       mem_alu_i,
  input  logic [1:0]            mem_wd_sel_i,
  input  logic [1:0]            mem_ld_size_i,
  input  logic                  mem_ld_unsigned_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic                  wb_valid_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]           instret_o
`endif
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

  logic                  valid_q;
  logic                  regwrite_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       pc_q;
  logic [XLEN-1:0]       imm_q;
  logic [XLEN-1:0]       alu_q;
  logic [1:0]            sel_q;
  logic [1:0]            size_q;
  logic                  uns_q;

  logic                  load_en;
  logic [XLEN-1:0]       load_data;

  // Pick the naturally aligned lane (low offset bits ignored), then sign- or
  // zero-extend it. Size 3 falls back to a word access on 32-bit datapaths.
  function automatic logic [XLEN-1:0] load_extend(
    input logic [XLEN-1:0]  data,
    input logic [OFF_W-1:0] off,
    input logic [1:0]       size,
    input logic             uns
  );
    logic [OFF_W-1:0]       lane;
    logic [XLEN-1:0]        sh;
    logic signed [XLEN-1:0] sext;
    logic [XLEN-1:0]        res;
    case (size)
      2'd0:    lane = off;
      2'd1:    lane = off & HALF_MASK;
      2'd2:    lane = off & WORD_MASK;
      default: lane = (XLEN == 64) ? '0 : (off & WORD_MASK);
    endcase
    sh = data >> {lane, 3'b000};
    case (size)
      2'd0: begin
        sext = $signed(sh[7:0]);
        res  = uns ? XLEN'(sh[7:0]) : sext;
      end
      2'd1: begin
        sext = $signed(sh[15:0]);
        res  = uns ? XLEN'(sh[15:0]) : sext;
      end
      default: begin
        sext = $signed(sh[31:0]);
        if (size == 2'd3 && XLEN == 64) res = sh;
        else                             res = uns ? XLEN'(sh[31:0]) : sext;
      end
    endcase
    return res;
  endfunction

  // A flush still captures the entering instruction's fields, only marked invalid.
  assign load_en = flush_i | ~stall_i;

  // WB pipeline register; stall holds, flush invalidates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      alu_q      <= '0;
      sel_q      <= 2'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
    end else if (load_en) begin
      valid_q    <= mem_valid_i & ~flush_i;
      regwrite_q <= mem_regwrite_i;
      rd_q       <= mem_rd_i;
      pc_q       <= mem_pc_i;
      imm_q      <= mem_imm_i;
      alu_q      <= mem_alu_i;
      sel_q      <= mem_wd_sel_i;
      size_q     <= mem_ld_size_i;
      uns_q      <= mem_ld_unsigned_i;
    end
  end

  // Load data arrives from DMEM during the WB cycle, so extraction is combinational.
  always_comb begin
    load_data = load_extend(dmem_rdata_i, alu_q[OFF_W-1:0], size_q, uns_q);
  end

  // Write-data mux and write enable; a stalled instruction writes when the stall lifts.
  always_comb begin
    case (sel_q)
      2'd0:    rf_wdata_o = pc_q + XLEN'(PC_STEP);
      2'd1:    rf_wdata_o = alu_q;
      2'd2:    rf_wdata_o = load_data;
      default: rf_wdata_o = imm_q;
    endcase
    rf_we_o    = valid_q & regwrite_q & (rd_q != '0) & ~stall_i;
    rf_waddr_o = rd_q;
    wb_valid_o = valid_q;
  end

`ifdef WB_INSTRET_EN
  // Count every instruction that leaves WB, whether or not it writes rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  instret_o <= 64'd0;
    else if (valid_q & ~stall_i) instret_o <= instret_o + 64'd1;
  end
`endif

endmodule

// File: doc/wb_stage_v2.md
Name: wb_stage_v2

Overview:
Parametrised write-back stage for the 5-stage pipeline. It registers MEM-stage results and selects the register-file write data from PC+4, ALU result, load data or immediate. It also extracts and sign/zero-extends sub-word load data, and supports stall and flush from the hazard unit. It drives the register-file write port and the forwarding path.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
REG_ADDR_W, 5, register address width
PC_STEP, 4, increment added to PC for link writes

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
stall_i  input  1  hold WB register contents; suppress write this cycle
flush_i  input  1  invalidate the instruction entering WB
mem_valid_i  input  1  MEM stage holds a real instruction
mem_regwrite_i  input  1  instruction writes rd
mem_rd_i  input  REG_ADDR_W  destination register
mem_pc_i  input  XLEN  instruction PC
mem_imm_i  input  XLEN  immediate (LUI path)
mem_alu_i  input  XLEN  ALU result / load address
mem_wd_sel_i  input  2  0=PC+PC_STEP, 1=ALU, 2=LOAD, 3=IMM
mem_ld_size_i  input  2  0=byte, 1=half, 2=word, 3=double
mem_ld_unsigned_i  input  1  zero-extend load when 1
dmem_rdata_i  input  XLEN  synchronous DMEM read data, valid in the WB cycle
rf_we_o  output  1  register-file write enable
rf_waddr_o  output  REG_ADDR_W  register-file write address
rf_wdata_o  output  XLEN  register-file write data
wb_valid_o  output  1  WB holds a valid instruction
instret_o  output  64  retired-instruction count (WB_INSTRET_EN only)

Behaviour:
- Pipeline register, updated on posedge clk. Fields: valid_q, regwrite_q, rd_q, pc_q, imm_q, alu_q, sel_q, size_q, uns_q.
- Reset (async): all fields 0. Outputs then read rf_we_o=0, rf_waddr_o=0, wb_valid_o=0, rf_wdata_o=PC_STEP (sel 0, pc 0), instret_o=0.
- Update priority per edge:
  - flush_i: valid_q<=0; other fields load normally.
  - else stall_i: all fields hold.
  - else: all fields load from mem_* inputs.
- Latency: one cycle from MEM inputs to rf_* outputs. DMEM data is used combinationally in the WB cycle.
- wb_valid_o = valid_q.
- rf_we_o = valid_q & regwrite_q & (rd_q != 0) & ~stall_i.
  - A stalled instruction writes once, in the cycle stall_i deasserts.
- rf_waddr_o = rd_q.
- rf_wdata_o, combinational on sel_q:
  - 0: pc_q + PC_STEP, truncated to XLEN (wraps at 2^XLEN)
  - 1: alu_q
  - 2: load data
  - 3: imm_q
- Load extraction uses byte offset off = alu_q[log2(XLEN/8)-1:0]:
  - byte: dmem_rdata_i[8*off +: 8]
  - half: lane selected by off with bit0 ignored
  - word: lane selected by off with bits[1:0] ignored (XLEN=64 uses off[2])
  - double: full word when XLEN=64; when XLEN=32, size 3 is treated as word
- Extension: sign-extend from the loaded MSB unless uns_q=1, then zero-extend.
- Misaligned offsets are never flagged. Low bits are ignored as above; alignment traps are handled in MEM.
- rd_q=0 never produces a write, whatever the other fields hold.
- flush and stall in the same cycle: flush wins. The held instruction becomes invalid and is never written.
- Reset asserted mid-stall discards the held instruction; no write follows deassertion.

Optional Feature:
WB_INSTRET_EN
- Defined: instret_o is a 64-bit counter, reset to 0. It increments by 1 on each edge where valid_q & ~stall_i, i.e. each retired instruction, including those with regwrite_q=0. It wraps from 2^64-1 to 0.
- Undefined: the instret_o port and counter are absent, and no retirement logic is synthesised.

Test Plan:
1. Reset, then release with no valid inputs -> rf_we_o=0, wb_valid_o=0, rf_waddr_o=0, rf_wdata_o=4.
2. JAL: sel=0, pc=0x100, rd=1 -> next cycle rf_we_o=1, rf_waddr_o=1, rf_wdata_o=0x104. Repeat with pc=0xFFFFFFFC -> 0x00000000.
3. Load byte, XLEN=32, dmem=0x80FF7F01, alu low bits=2: signed -> 0xFFFFFFFF; unsigned -> 0x000000FF. Half, off=2, signed -> 0xFFFF80FF.
4. ALU write to rd=0 (alu=0x1234) -> rf_we_o stays 0. IMM write to rd=5, imm=0xABCDE000 -> rf_wdata_o=0xABCDE000.
5. Stall 3 cycles on valid ALU write rd=7 -> rf_we_o=0 during stall, then exactly one 1-cycle write. With WB_INSTRET_EN, instret_o advances by 1.
6. stall_i and flush_i together on a valid instruction -> wb_valid_o=0 next cycle, no write, instret_o unchanged.
